llc_lookup_ctrl: RTL and testbench

LLC_LOOKUP_CTRL -- requirements
Module: llc_lookup_ctrl

---
 rtl/llc_lookup_ctrl_pkg.sv | 24 ++
 rtl/llc_lookup_ctrl_if.sv | 31 +++
 rtl/llc_rr_arbiter.sv | 29 ++
 rtl/llc_lookup_ctrl.sv | 144 ++++++++++++++
 tb/tb_llc_lookup_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_lookup_ctrl_pkg.sv
// Shared LLC geometry constants and types used by the lookup controller,
// its requester/response interface and the round-robin arbiter.
package llc_lookup_ctrl_pkg;

    localparam int LLC_WAYS     = 16;
    localparam int LLC_WAY_BITS = 4;
    localparam int LLC_SET_BITS = 7;
    localparam int LLC_TAG_BITS = 12;

    typedef logic [LLC_WAY_BITS-1:0] llc_way_t;
    typedef logic [LLC_SET_BITS-1:0] llc_set_t;
    typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;

    // Width of a requester index; a lone requester still needs one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Replacement pointer advance, wrapping the last way back to way 0.
    function automatic llc_way_t next_way(input llc_way_t way);
        return (way == llc_way_t'(LLC_WAYS - 1)) ? '0 : way + llc_way_t'(1);
    endfunction

endpackage

// File: rtl/llc_lookup_ctrl_if.sv
// Requester-side lookup handshake and result handshake of the LLC lookup
// controller; master = requesters/consumer, slave = controller.
interface llc_lookup_ctrl_if
    import llc_lookup_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    llc_set_t [NUM_REQ-1:0] req_set;
    llc_tag_t [NUM_REQ-1:0] req_tag;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    llc_way_t               rsp_way;
    logic                   rsp_evict;

    modport master (
        output req_valid, req_set, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_way, rsp_evict
    );

    modport slave (
        input  req_valid, req_set, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_way, rsp_evict
    );

endinterface

// File: rtl/llc_rr_arbiter.sv
// Combinational round-robin arbiter: the first active request found scanning
// upward from rr_ptr (wrapping) wins a one-hot grant.
module llc_rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every variable written here is defaulted first, so no path through the loop can infer a latch.
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/llc_lookup_ctrl.sv
// LLC lookup sequencer: arbitrates one requester, reads its set, runs the way
// lookup, writes back the replacement pointer on eviction and returns the result.
module llc_lookup_ctrl
    import llc_lookup_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    llc_lookup_ctrl_if.slave        bus,
    output logic                    mem_rd_en,
    output llc_set_t                mem_rd_set,
    input  logic                    mem_rd_valid,
    output logic                    lookup_en,
    output llc_tag_t                lookup_tag,
    input  llc_way_t                lookup_way,
    input  logic                    lookup_evict,
    input  llc_way_t                evict_way_buf,
    output logic                    evict_wr_en,
    output llc_set_t                evict_wr_set,
    output llc_way_t                evict_wr_way,
    output logic                    busy
);

    localparam int ID_W = id_width(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        LOOKUP,
        CAPTURE,
        RSP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   gnt_idx;
    llc_set_t          set_q;
    llc_tag_t          tag_q;
    logic [ID_W-1:0]   id_q;
    llc_way_t          way_q;
    logic              evict_q;
    logic              evict_buf_unused;

    // The new pointer is derived from the lookup result, so the buffered copy is not consumed.
    assign evict_buf_unused = ^evict_way_buf;

    llc_rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        mem_rd_en     = 1'b0;
        lookup_en     = 1'b0;
        evict_wr_en   = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && |bus.req_valid) begin
                    bus.req_ready = grant;
                    state_nxt     = RD;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rd_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                lookup_en = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                evict_wr_en = lookup_evict;
                state_nxt   = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction fields: latched at grant, result captured after the lookup.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            set_q   <= '0;
            tag_q   <= '0;
            id_q    <= '0;
            way_q   <= '0;
            evict_q <= 1'b0;
        end else begin
            if (state == IDLE && |bus.req_valid) begin
                set_q <= bus.req_set[gnt_idx];
                tag_q <= bus.req_tag[gnt_idx];
                id_q  <= gnt_idx;
            end
            if (state == CAPTURE) begin
                way_q   <= lookup_way;
                evict_q <= lookup_evict;
            end
            if (state == RSP && bus.rsp_ready) begin
                rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
        end
    end

    assign mem_rd_set    = set_q;
    assign lookup_tag    = tag_q;
    assign evict_wr_set  = set_q;
    assign evict_wr_way  = next_way(lookup_way);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_way   = way_q;
    assign bus.rsp_evict = evict_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_llc_lookup_ctrl.sv
// Self-checking bench for llc_lookup_ctrl: scripted and randomized lookups
// compared against a transaction-level round-robin model.
module tb_llc_lookup_ctrl;
    import llc_lookup_ctrl_pkg::*;

    localparam int NR  = 3;
    localparam int IDW = 2;

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    logic     mem_rd_en;
    llc_set_t mem_rd_set;
    logic     mem_rd_valid;
    logic     lookup_en;
    llc_tag_t lookup_tag;
    llc_way_t lookup_way;
    logic     lookup_evict;
    llc_way_t evict_way_buf;
    logic     evict_wr_en;
    llc_set_t evict_wr_set;
    llc_way_t evict_wr_way;
    logic     busy;

    int checks = 0;
    int errors = 0;
    int rr_model = 0;
    llc_set_t set_tb [NR];
    llc_tag_t tag_tb [NR];

    llc_lookup_ctrl_if #(.NUM_REQ(NR)) bus ();

    llc_lookup_ctrl #(.NUM_REQ(NR)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_set    (mem_rd_set),
        .mem_rd_valid  (mem_rd_valid),
        .lookup_en     (lookup_en),
        .lookup_tag    (lookup_tag),
        .lookup_way    (lookup_way),
        .lookup_evict  (lookup_evict),
        .evict_way_buf (evict_way_buf),
        .evict_wr_en   (evict_wr_en),
        .evict_wr_set  (evict_wr_set),
        .evict_wr_way  (evict_wr_way),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Round-robin rule: first requesting index at or after the pointer, wrapping.
    function automatic int model_winner(input logic [NR-1:0] reqs);
        for (int k = 0; k < NR; k++) begin
            if (reqs[(rr_model + k) % NR]) return (rr_model + k) % NR;
        end
        return -1;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < NR; i++) begin
            set_tb[i] = llc_set_t'($urandom);
            tag_tb[i] = llc_tag_t'($urandom);
        end
    endtask

    // Idle cycles with no requests; mem_rd_valid may be driven spuriously.
    task automatic idle_cycles(input int n, input logic spur);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.req_valid = '0;
            mem_rd_valid  = spur;
            #1;
            checks++;
            if ({bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy} !== '0) begin
                errors++;
                $display("FAIL idle_quiet: got rdy=%b rd=%b lk=%b ev=%b rsp=%b busy=%b, want all 0",
                         bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy);
            end
        end
        mem_rd_valid = 1'b0;
    endtask

    // One complete transaction starting in an IDLE cycle; req_valid held at reqs throughout.
    task automatic do_txn(input logic [NR-1:0] reqs, input int mem_dly, input llc_way_t lw,
                          input logic le, input int rsp_dly, input logic spur, output int obs_g);
        int            g;
        logic [NR-1:0] exp_gnt;
        llc_way_t      exp_ev_way;
        g          = model_winner(reqs);
        exp_gnt    = '0;
        exp_gnt[g] = 1'b1;
        exp_ev_way = llc_way_t'((int'(lw) + 1) % LLC_WAYS);
        obs_g      = -1;
        for (int i = 0; i < NR; i++) begin
            bus.req_set[i] = set_tb[i];
            bus.req_tag[i] = tag_tb[i];
        end

        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = reqs;
        mem_rd_valid  = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) obs_g = i;
        checks++;
        if ({bus.req_ready, busy, mem_rd_en} !== {exp_gnt, 2'b00}) begin
            errors++;
            $display("FAIL grant: got ready=%b busy=%b rd=%b, want ready=%b busy=0 rd=0",
                     bus.req_ready, busy, mem_rd_en, exp_gnt);
        end

        @(negedge clk);
        mem_rd_valid = spur;
        #1;
        checks++;
        if ({mem_rd_en, mem_rd_set, bus.req_ready, busy, lookup_tag} !== {1'b1, set_tb[g], 3'b000, 1'b1, tag_tb[g]}) begin
            errors++;
            $display("FAIL rd_issue: got en=%b set=%h ready=%b busy=%b tag=%h, want en=1 set=%h ready=000 busy=1 tag=%h",
                     mem_rd_en, mem_rd_set, bus.req_ready, busy, lookup_tag, set_tb[g], tag_tb[g]);
        end

        for (int d = 0; d < mem_dly; d++) begin
            @(negedge clk);
            mem_rd_valid = 1'b0;
            #1;
            checks++;
            if ({mem_rd_en, lookup_en, bus.rsp_valid, bus.req_ready, busy, lookup_tag} !== {3'b000, 3'b000, 1'b1, tag_tb[g]}) begin
                errors++;
                $display("FAIL wait_hold: got rd=%b lk=%b rsp=%b ready=%b busy=%b tag=%h, want 0 0 0 000 1 tag=%h",
                         mem_rd_en, lookup_en, bus.rsp_valid, bus.req_ready, busy, lookup_tag, tag_tb[g]);
            end
        end

        @(negedge clk);
        mem_rd_valid = 1'b1;
        #1;
        checks++;
        if ({lookup_en, mem_rd_en, bus.req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL wait_seen: got lk=%b rd=%b ready=%b, want all 0", lookup_en, mem_rd_en, bus.req_ready);
        end

        @(negedge clk);
        mem_rd_valid = 1'b0;
        lookup_way   = llc_way_t'($urandom);
        lookup_evict = 1'($urandom);
        #1;
        checks++;
        if ({lookup_en, lookup_tag, evict_wr_en, bus.rsp_valid} !== {1'b1, tag_tb[g], 2'b00}) begin
            errors++;
            $display("FAIL lookup: got en=%b tag=%h ev=%b rsp=%b, want en=1 tag=%h ev=0 rsp=0",
                     lookup_en, lookup_tag, evict_wr_en, bus.rsp_valid, tag_tb[g]);
        end

        @(negedge clk);
        lookup_way   = lw;
        lookup_evict = le;
        #1;
        checks++;
        if ({lookup_en, evict_wr_en, bus.rsp_valid, lookup_tag} !== {1'b0, le, 1'b0, tag_tb[g]}) begin
            errors++;
            $display("FAIL capture: got lk=%b ev=%b rsp=%b tag=%h, want lk=0 ev=%b rsp=0 tag=%h",
                     lookup_en, evict_wr_en, bus.rsp_valid, lookup_tag, le, tag_tb[g]);
        end
        if (le) begin
            checks++;
            if ({evict_wr_set, evict_wr_way} !== {set_tb[g], exp_ev_way}) begin
                errors++;
                $display("FAIL evict_wr: got set=%h way=%0d, want set=%h way=%0d",
                         evict_wr_set, evict_wr_way, set_tb[g], exp_ev_way);
            end
        end

        for (int r = 0; r <= rsp_dly; r++) begin
            @(negedge clk);
            bus.rsp_ready = (r == rsp_dly);
            lookup_way    = llc_way_t'($urandom);
            lookup_evict  = 1'($urandom);
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_way, bus.rsp_evict, bus.req_ready, evict_wr_en, busy, lookup_tag}
                !== {1'b1, IDW'(g), lw, le, 3'b000, 1'b0, 1'b1, tag_tb[g]}) begin
                errors++;
                $display("FAIL rsp: got v=%b id=%0d way=%0d ev=%b ready=%b evwr=%b busy=%b tag=%h, want v=1 id=%0d way=%0d ev=%b ready=000 evwr=0 busy=1 tag=%h",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_way, bus.rsp_evict, bus.req_ready, evict_wr_en,
                         busy, lookup_tag, g, lw, le, tag_tb[g]);
            end
        end
        rr_model = (g + 1) % NR;
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        mem_rd_valid  = 1'b0;
        lookup_way    = '0;
        lookup_evict  = 1'b0;
        evict_way_buf = '0;
        rst           = 1'b1;
        rand_fields();
        for (int i = 0; i < NR; i++) begin
            bus.req_set[i] = set_tb[i];
            bus.req_tag[i] = tag_tb[i];
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy, lookup_tag, mem_rd_set} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b rd=%b lk=%b ev=%b rsp=%b busy=%b tag=%h set=%h, want all 0",
                     bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy, lookup_tag, mem_rd_set);
        end
        @(negedge clk);
        rst = 1'b0;
        rr_model = 0;
        idle_cycles(2, 1'b0);
    endtask

    task automatic test_rr_order();
        int exp_order [4];
        int obs;
        exp_order = '{0, 1, 2, 0};
        for (int t = 0; t < 4; t++) begin
            rand_fields();
            do_txn(3'b111, 1, llc_way_t'($urandom), 1'($urandom), 0, 1'b0, obs);
            checks++;
            if (obs !== exp_order[t]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got grant %0d, want %0d", t, obs, exp_order[t]);
            end
        end
    endtask

    task automatic test_basic();
        int obs;
        rand_fields();
        set_tb[1] = 7'h05;
        tag_tb[1] = 12'h01A;
        do_txn(3'b010, 0, 4'd3, 1'b0, 0, 1'b0, obs);
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_evict_wrap();
        int obs;
        rand_fields();
        set_tb[0] = 7'h7F;
        do_txn(3'b001, 0, 4'd15, 1'b1, 1, 1'b0, obs);
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int obs;
        rand_fields();
        do_txn(3'b111, 2, llc_way_t'($urandom), 1'b1, 4, 1'b0, obs);
        do_txn(3'b111, 0, llc_way_t'($urandom), 1'b0, 0, 1'b0, obs);
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_mem_delay();
        int obs;
        idle_cycles(3, 1'b1);
        rand_fields();
        do_txn(3'b100, 4, llc_way_t'($urandom), 1'b0, 0, 1'b1, obs);
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int obs;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 3'b010;
        #1;
        checks++;
        if (bus.req_ready !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b, want 010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, mem_rd_en, lookup_en} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_wait: got busy=%b rd=%b lk=%b, want 1 0 0", busy, mem_rd_en, lookup_en);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        mem_rd_valid = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_after: got rdy=%b rd=%b lk=%b ev=%b rsp=%b busy=%b, want all 0",
                     bus.req_ready, mem_rd_en, lookup_en, evict_wr_en, bus.rsp_valid, busy);
        end
        rr_model = 0;
        idle_cycles(3, 1'b1);
        rand_fields();
        do_txn(3'b100, 1, llc_way_t'($urandom), 1'($urandom), 0, 1'b0, obs);
        checks++;
        if (obs !== 2) begin
            errors++;
            $display("FAIL reset_mid_next: got grant %0d, want 2", obs);
        end
        idle_cycles(1, 1'b0);
    endtask

    task automatic test_random();
        int obs;
        for (int t = 0; t < 25; t++) begin
            rand_fields();
            do_txn(NR'($urandom_range(1, 7)), $urandom_range(0, 4), llc_way_t'($urandom),
                   1'($urandom), $urandom_range(0, 3), 1'($urandom), obs);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_basic();
        test_evict_wrap();
        test_back_to_back();
        test_mem_delay();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
